decoder_pipe: RTL and testbench
===============================

# decoder_pipe

Parametrised, pipelined binary-to-one-hot decoder with valid/ready handshakes on both sides. It generalises the fixed 3-to-8 combinational decoder to any code width and output count, and adds out-of-range detection and back-pressure buffering. An optional built-in sweep generator exercises every output. It sits between a code producer (FSM or register file) and one-hot consumers such as LED banks, chip-selects or mux selects.

## Interface
- IN_W, 3, code width in bits (1..8)
- OUT_N, 8, number of one-hot outputs; 2 ≤ OUT_N ≤ 2^IN_W
- sys_clk  in  1  clock; all logic on the rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  in_code is valid
- in_ready  out  1  block can accept a code
- in_code  in  IN_W  binary code
- out_valid  out  1  out/out_err are valid
- out_ready  in  1  consumer accepts the current output
- out  out  OUT_N  one-hot result; bit k set when code == k
- out_err  out  1  code ≥ OUT_N; out is all zeros
- scan_en  in  1  sweep mode request (only with DECODER_SCAN_EN)

## Operation
- Input transfer: in_valid && in_ready on a clock edge.
- Output transfer: out_valid && out_ready on a clock edge.
- Decode rule:
  - code < OUT_N: out = 1 << code, out_err = 0.
  - Otherwise: out = 0, out_err = 1.
- Storage: the output register plus one skid entry, so at most 2 codes are in flight.
- in_ready is registered and equals !skid_full.
- Output register:
  - Loads when empty, or when it transfers in the same cycle.
  - Source: the skid entry if occupied, else the incoming code.
- Skid entry loads when an input transfer occurs while the output register is full and not transferring.
- Ordering is strict FIFO; no code is dropped or duplicated.
- Reset: out_valid=0, out=0, out_err=0, in_ready=0, skid empty, scan counter=0.
  - in_ready rises on the first edge after sys_rst_n returns high.
- Reset asserted mid-transfer discards both stored codes; nothing is emitted afterwards.

## Timing
- Latency: accept on edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 code/cycle while out_ready=1.
- Stall:
  - With out_ready=0, one further code is absorbed into the skid entry.
  - in_ready falls after the edge that filled the skid.
  - in_ready returns 1 the cycle after the first output transfer that drains the skid.
- Simultaneous input and output transfer with the skid empty: the output register takes the new code; in_ready stays 1.
- out/out_err hold stable while out_valid=1 and out_ready=0.

## Configuration
- DECODER_SCAN_EN defined:
  - Adds the scan_en port and an internal counter scan_cnt of width IN_W.
  - While scan_en=1, in_ready is forced 0 and scan_cnt is pushed as the code whenever the internal ready is 1.
  - scan_cnt increments per push, wrapping from OUT_N-1 to 0. Out-of-range codes are never generated.
  - scan_en 1→0 clears scan_cnt to 0 on that edge. Codes already in flight complete normally.
  - scan_en 0→1 takes effect the next cycle. An input transfer on the switching edge is still honoured.
- DECODER_SCAN_EN undefined: no scan_en port and no counter; the block behaves as an external-input decoder only.

## Structure
- Package decoder_pkg holds:
  - Function onehot_dec(code, OUT_N), returning the one-hot vector and error flag.
  - Localparam check that OUT_N ≤ 2^IN_W, with elaboration error if violated.
- Sub-module hs_skid_buf: generic 2-entry valid/ready skid buffer, parametrised on data width.
  - Instantiated with data = {out_err, out}.
  - Decode happens before the buffer, so stored data is already decoded.
- The top level contains the decode, scan counter, mux and instance only.

## Test plan
- Reset release, IN_W=3, OUT_N=8: all outputs 0 during reset; in_ready=1 one cycle after release; out_valid stays 0.
- Stream codes 0..7 with in_valid=1, out_ready=1: out = 00000001…10000000 on consecutive cycles, 1-cycle latency, out_err=0.
- IN_W=3, OUT_N=6, codes 5,6,7: out=100000/err=0, then out=000000/err=1 twice.
- out_ready=0 while pushing codes 2,3,4: only 2 and 3 are accepted and in_ready drops. Releasing out_ready gives 00000100, 00001000, then 00010000 with no loss or reordering.
- sys_rst_n low for 1 cycle with 2 codes held: out_valid=0 the next cycle; the stored codes are never emitted.
- DECODER_SCAN_EN, OUT_N=5, scan_en=1 for 12 cycles with out_ready=1:
  - Outputs cycle 1,2,4,8,16,1,…; in_ready=0 throughout.
  - After scan_en drops, the next scan restarts at 00001.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for decoder_pipe: generic one-hot decode with range check,
// plus the parameter legality check used at elaboration.
package decoder_pkg;

   localparam int MAX_W = 8;
   localparam int MAX_N = 1 << MAX_W;

   typedef struct packed {
      logic             err;
      logic [MAX_N-1:0] vec;
   } dec_t;

   // Caller keeps vec[out_n-1:0]; bits above out_n are always zero.
   function automatic dec_t onehot_dec(input logic [MAX_W-1:0] code, input int out_n);
      dec_t r;
      r.err = 1'b0;
      r.vec = '0;
      if (int'(code) < out_n)
         r.vec[code] = 1'b1;
      else
         r.err = 1'b1;
      return r;
   endfunction

   function automatic bit cfg_ok(input int in_w, input int out_n);
      return (in_w >= 1) && (in_w <= MAX_W) && (out_n >= 2) && (out_n <= (1 << in_w));
   endfunction

endpackage

// File: rtl/decoder_pipe_skid.sv
// Two-entry valid/ready skid buffer: output register plus one skid slot, strict FIFO.
// One cycle latency; src_rdy is a register equal to "skid empty", so one extra word is absorbed on a stall.
module hs_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         src_vld,
   output logic         src_rdy,
   input  logic [W-1:0] src_dat,
   output logic         dst_vld,
   input  logic         dst_rdy,
   output logic [W-1:0] dst_dat
);

   logic         skid_vld;
   logic [W-1:0] skid_dat;
   logic         skid_vld_nxt;
   logic         src_xfer;
   logic         dst_xfer;
   logic         out_load;
   logic         skid_load;

   assign src_xfer  = src_vld && src_rdy;
   assign dst_xfer  = dst_vld && dst_rdy;
   assign out_load  = !dst_vld || dst_xfer;
   assign skid_load = src_xfer && dst_vld && !dst_xfer;

   always_comb begin
      skid_vld_nxt = skid_vld;
      if (skid_load)
         skid_vld_nxt = 1'b1;
      else if (out_load)
         skid_vld_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_rdy  <= 1'b0;
         dst_vld  <= 1'b0;
         dst_dat  <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else begin
         src_rdy  <= !skid_vld_nxt;
         skid_vld <= skid_vld_nxt;
         // The skid word is older than anything arriving now, so it drains first.
         if (out_load) begin
            dst_vld <= skid_vld || src_xfer;
            if (skid_vld)
               dst_dat <= skid_dat;
            else if (src_xfer)
               dst_dat <= src_dat;
         end
         if (skid_load)
            skid_dat <= src_dat;
      end
   end

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined binary-to-one-hot decoder with range error, 1-cycle latency, 2-entry skid back-pressure.
// Optional sweep generator under DECODER_SCAN_EN (adds scan_en port and scan_cnt).
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter int IN_W  = 3,
   parameter int OUT_N = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_N-1:0] out,
   output logic             out_err
`ifdef DECODER_SCAN_EN
   ,
   input  logic             scan_en
`endif
);

   localparam bit CFG_OK = cfg_ok(IN_W, OUT_N);

   if (!CFG_OK) begin : g_bad_cfg
      $error("decoder_pipe: requires 1 <= IN_W <= 8 and 2 <= OUT_N <= 2**IN_W");
   end

   logic             push_vld;
   logic [IN_W-1:0]  push_code;
   logic             buf_rdy;
   logic [MAX_W-1:0] code_ext;
   dec_t             dec;
   logic             unused_vec;

`ifdef DECODER_SCAN_EN
   logic            scan_q;
   logic            scan_act;
   logic [IN_W-1:0] scan_cnt;

   // Turning on is delayed a cycle so a transfer on the switching edge is kept; turning off is immediate.
   assign scan_act = scan_q && scan_en;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         scan_q   <= 1'b0;
         scan_cnt <= '0;
      end else begin
         scan_q <= scan_en;
         if (!scan_en)
            scan_cnt <= '0;
         else if (scan_act && buf_rdy)
            scan_cnt <= (scan_cnt == IN_W'(OUT_N - 1)) ? '0 : scan_cnt + IN_W'(1);
      end
   end

   assign push_vld  = scan_act ? 1'b1 : in_valid;
   assign push_code = scan_act ? scan_cnt : in_code;
   assign in_ready  = buf_rdy && !scan_act;
`else
   assign push_vld  = in_valid;
   assign push_code = in_code;
   assign in_ready  = buf_rdy;
`endif

   assign code_ext = MAX_W'(push_code);

   always_comb begin
      dec = onehot_dec(code_ext, OUT_N);
   end

   assign unused_vec = ^dec.vec;

   hs_skid_buf #(
      .W (OUT_N + 1)
   ) u_buf (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .src_vld (push_vld),
      .src_rdy (buf_rdy),
      .src_dat ({dec.err, dec.vec[OUT_N-1:0]}),
      .dst_vld (out_valid),
      .dst_rdy (out_ready),
      .dst_dat ({out_err, out})
   );

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: 3->8 and 3->6 instances, plus a 3->5 sweep instance with DECODER_SCAN_EN.
module tb_decoder_pipe;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic sys_rst_n;
   int   n_vec = 0;
   int   n_bad = 0;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
   logic [2:0] a_in_code;
   logic [7:0] a_out;

   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
   logic [2:0] b_in_code;
   logic [5:0] b_out;

`ifdef DECODER_SCAN_EN
   logic       scan_off = 1'b0;
   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err, c_scan_en;
   logic [2:0] c_in_code;
   logic [4:0] c_out;
`endif

   decoder_pipe #(.IN_W(3), .OUT_N(8)) dut_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_code   (a_in_code),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out       (a_out),
      .out_err   (a_out_err)
`ifdef DECODER_SCAN_EN
      ,
      .scan_en   (scan_off)
`endif
   );

   decoder_pipe #(.IN_W(3), .OUT_N(6)) dut_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_code   (b_in_code),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out       (b_out),
      .out_err   (b_out_err)
`ifdef DECODER_SCAN_EN
      ,
      .scan_en   (scan_off)
`endif
   );

`ifdef DECODER_SCAN_EN
   decoder_pipe #(.IN_W(3), .OUT_N(5)) dut_c (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_valid  (c_in_valid),
      .in_ready  (c_in_ready),
      .in_code   (c_in_code),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out       (c_out),
      .out_err   (c_out_err),
      .scan_en   (c_scan_en)
   );
`endif

   task automatic step;
      @(posedge sys_clk);
      #1;
   endtask

   // Observation tuples are {out_valid, out_err, in_ready, out}.
   task automatic test_reset;
      logic [10:0] exp_a;
      logic [8:0]  exp_b;
      sys_rst_n   = 1'b0;
      a_in_valid  = 1'b0; a_in_code = '0; a_out_ready = 1'b0;
      b_in_valid  = 1'b0; b_in_code = '0; b_out_ready = 1'b0;
      step;
      step;
      exp_a = '0;
      n_vec++;
      if ({a_out_valid, a_out_err, a_in_ready, a_out} !== exp_a) begin
         n_bad++;
         $display("FAIL reset_hold_a: got %b want %b", {a_out_valid, a_out_err, a_in_ready, a_out}, exp_a);
      end
      sys_rst_n = 1'b1;
      n_vec++;
      if (a_in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_rdy_early: got %b want 0", a_in_ready);
      end
      step;
      exp_a = {1'b0, 1'b0, 1'b1, 8'h00};
      n_vec++;
      if ({a_out_valid, a_out_err, a_in_ready, a_out} !== exp_a) begin
         n_bad++;
         $display("FAIL reset_release_a: got %b want %b", {a_out_valid, a_out_err, a_in_ready, a_out}, exp_a);
      end
      exp_b = {1'b0, 1'b0, 1'b1, 6'h00};
      n_vec++;
      if ({b_out_valid, b_out_err, b_in_ready, b_out} !== exp_b) begin
         n_bad++;
         $display("FAIL reset_release_b: got %b want %b", {b_out_valid, b_out_err, b_in_ready, b_out}, exp_b);
      end
   endtask

   task automatic test_stream;
      logic [10:0] exp_a;
      logic [7:0]  one;
      one = 8'b0000_0001;
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_in_code = 3'(i);
         step;
         exp_a = {1'b1, 1'b0, 1'b1, one << i};
         n_vec++;
         if ({a_out_valid, a_out_err, a_in_ready, a_out} !== exp_a) begin
            n_bad++;
            $display("FAIL stream_code%0d: got %b want %b", i, {a_out_valid, a_out_err, a_in_ready, a_out}, exp_a);
         end
      end
      a_in_valid = 1'b0;
      step;
      n_vec++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL stream_drain: got vld/rdy %b want 01", {a_out_valid, a_in_ready});
      end
   endtask

   task automatic test_range;
      logic [8:0] exp_tab [3];
      logic [2:0] code_tab [3];
      code_tab[0] = 3'd5; exp_tab[0] = {1'b1, 1'b0, 1'b1, 6'b100000};
      code_tab[1] = 3'd6; exp_tab[1] = {1'b1, 1'b1, 1'b1, 6'b000000};
      code_tab[2] = 3'd7; exp_tab[2] = {1'b1, 1'b1, 1'b1, 6'b000000};
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_in_code = code_tab[i];
         step;
         n_vec++;
         if ({b_out_valid, b_out_err, b_in_ready, b_out} !== exp_tab[i]) begin
            n_bad++;
            $display("FAIL range_code%0d: got %b want %b", code_tab[i], {b_out_valid, b_out_err, b_in_ready, b_out}, exp_tab[i]);
         end
      end
      b_in_valid = 1'b0;
      step;
      n_vec++;
      if (b_out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL range_drain: got vld %b want 0", b_out_valid);
      end
   endtask

   task automatic test_stall;
      logic [10:0] exp_tab [5];
      logic [2:0]  code_tab [5];
      logic        ordy_tab [5];
      code_tab[0] = 3'd2; ordy_tab[0] = 1'b0; exp_tab[0] = {1'b1, 1'b0, 1'b1, 8'b0000_0100};
      code_tab[1] = 3'd3; ordy_tab[1] = 1'b0; exp_tab[1] = {1'b1, 1'b0, 1'b0, 8'b0000_0100};
      code_tab[2] = 3'd4; ordy_tab[2] = 1'b0; exp_tab[2] = {1'b1, 1'b0, 1'b0, 8'b0000_0100};
      code_tab[3] = 3'd4; ordy_tab[3] = 1'b1; exp_tab[3] = {1'b1, 1'b0, 1'b1, 8'b0000_1000};
      code_tab[4] = 3'd4; ordy_tab[4] = 1'b1; exp_tab[4] = {1'b1, 1'b0, 1'b1, 8'b0001_0000};
      a_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a_in_code   = code_tab[i];
         a_out_ready = ordy_tab[i];
         step;
         n_vec++;
         if ({a_out_valid, a_out_err, a_in_ready, a_out} !== exp_tab[i]) begin
            n_bad++;
            $display("FAIL stall_step%0d: got %b want %b", i, {a_out_valid, a_out_err, a_in_ready, a_out}, exp_tab[i]);
         end
      end
      a_in_valid = 1'b0;
      step;
      n_vec++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL stall_drain: got vld/rdy %b want 01", {a_out_valid, a_in_ready});
      end
   endtask

   task automatic test_reset_mid;
      logic [10:0] exp_a;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_code   = 3'd1;
      step;
      a_in_code   = 3'd5;
      step;
      n_vec++;
      if ({a_out_valid, a_in_ready, a_out} !== {1'b1, 1'b0, 8'b0000_0010}) begin
         n_bad++;
         $display("FAIL rstmid_full: got %b want %b", {a_out_valid, a_in_ready, a_out}, {1'b1, 1'b0, 8'b0000_0010});
      end
      a_in_valid = 1'b0;
      sys_rst_n  = 1'b0;
      step;
      exp_a = '0;
      n_vec++;
      if ({a_out_valid, a_out_err, a_in_ready, a_out} !== exp_a) begin
         n_bad++;
         $display("FAIL rstmid_cleared: got %b want %b", {a_out_valid, a_out_err, a_in_ready, a_out}, exp_a);
      end
      sys_rst_n   = 1'b1;
      a_out_ready = 1'b1;
      exp_a = {1'b0, 1'b0, 1'b1, 8'h00};
      for (int i = 0; i < 4; i++) begin
         step;
         n_vec++;
         if ({a_out_valid, a_out_err, a_in_ready, a_out} !== exp_a) begin
            n_bad++;
            $display("FAIL rstmid_after%0d: got %b want %b", i, {a_out_valid, a_out_err, a_in_ready, a_out}, exp_a);
         end
      end
   endtask

`ifdef DECODER_SCAN_EN
   task automatic test_scan;
      logic [7:0] exp_c;
      logic [4:0] one;
      one = 5'b00001;
      c_out_ready = 1'b1;
      c_in_valid  = 1'b0;
      c_in_code   = '0;
      c_scan_en   = 1'b1;
      step;
      exp_c = {1'b0, 1'b0, 1'b0, 5'b00000};
      n_vec++;
      if ({c_out_valid, c_out_err, c_in_ready, c_out} !== exp_c) begin
         n_bad++;
         $display("FAIL scan_start: got %b want %b", {c_out_valid, c_out_err, c_in_ready, c_out}, exp_c);
      end
      for (int k = 0; k < 11; k++) begin
         step;
         exp_c = {1'b1, 1'b0, 1'b0, one << (k % 5)};
         n_vec++;
         if ({c_out_valid, c_out_err, c_in_ready, c_out} !== exp_c) begin
            n_bad++;
            $display("FAIL scan_cycle%0d: got %b want %b", k, {c_out_valid, c_out_err, c_in_ready, c_out}, exp_c);
         end
      end
      c_scan_en = 1'b0;
      step;
      n_vec++;
      if ({c_out_valid, c_in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL scan_stop: got vld/rdy %b want 01", {c_out_valid, c_in_ready});
      end
      // External code on the enabling edge is still taken; the sweep restarts from 0 right after.
      c_scan_en  = 1'b1;
      c_in_valid = 1'b1;
      c_in_code  = 3'd3;
      step;
      c_in_valid = 1'b0;
      exp_c = {1'b1, 1'b0, 1'b0, 5'b01000};
      n_vec++;
      if ({c_out_valid, c_out_err, c_in_ready, c_out} !== exp_c) begin
         n_bad++;
         $display("FAIL scan_switch_edge: got %b want %b", {c_out_valid, c_out_err, c_in_ready, c_out}, exp_c);
      end
      step;
      exp_c = {1'b1, 1'b0, 1'b0, 5'b00001};
      n_vec++;
      if ({c_out_valid, c_out_err, c_in_ready, c_out} !== exp_c) begin
         n_bad++;
         $display("FAIL scan_restart: got %b want %b", {c_out_valid, c_out_err, c_in_ready, c_out}, exp_c);
      end
      c_scan_en = 1'b0;
      step;
      n_vec++;
      if (c_out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL scan_final_drain: got vld %b want 0", c_out_valid);
      end
   endtask
`endif

   initial begin
`ifdef DECODER_SCAN_EN
      c_in_valid  = 1'b0;
      c_in_code   = '0;
      c_out_ready = 1'b0;
      c_scan_en   = 1'b0;
`endif
      test_reset;
      test_stream;
      test_range;
      test_stall;
      test_reset_mid;
`ifdef DECODER_SCAN_EN
      test_scan;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
